// File: rtl/scan_drv_pkg.sv
// ---------------------------------------------------------------------------
// scan_drv_pkg
//
// Shared definitions for the scan pattern driver:
//   - scan_state_t : controller states (IDLE, SHIFT, CAPTURE, FLUSH, DONE)
//   - MISR_POLY    : feedback polynomial folded in when the MSB shifts out
//   - MISR_SEED    : signature value loaded at reset and at session start
// ---------------------------------------------------------------------------
package scan_drv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        FLUSH,
        DONE
    } scan_state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/scan_pattern_driver_misr.sv
// ---------------------------------------------------------------------------
// scan_misr
//
// Serial-input signature register. Each enabled cycle shifts the signature
// left by one, folds in MISR_POLY when the outgoing MSB is set, and XORs the
// serial response bit into bit 0. A seed request takes priority over an
// update so that a new session always starts from a clean signature.
//
// Ports:
//   CK   in   clock, rising edge
//   RN   in   asynchronous active-low reset (signature returns to the seed)
//   seed in   load MISR_SEED on the next edge
//   en   in   fold din into the signature on the next edge
//   din  in   serial response bit
//   sig  out  current signature
// ---------------------------------------------------------------------------
module scan_misr
    import scan_drv_pkg::*;
#(
    parameter int MISR_W = 16
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              seed,
    input  logic              en,
    input  logic              din,
    output logic [MISR_W-1:0] sig
);

    localparam logic [MISR_W-1:0] POLY = MISR_W'(MISR_POLY);
    localparam logic [MISR_W-1:0] SEED = MISR_W'(MISR_SEED);

    logic [MISR_W-1:0] sig_next;

    // One LFSR step with the serial bit injected at the low end.
    always_comb begin
        sig_next = {sig[MISR_W-2:0], 1'b0};
        if (sig[MISR_W-1]) begin
            sig_next = sig_next ^ POLY;
        end
        sig_next[0] = sig_next[0] ^ din;
    end

    // Signature register: seed wins over a regular update.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            sig <= SEED;
        end else if (seed) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/scan_pattern_driver.sv
// ---------------------------------------------------------------------------
// scan_pattern_driver
//
// Tester-side scan chain master. Serialises stimulus words (LSB first) onto
// test_si with test_se high, issues one capture cycle per pattern, unloads
// the previous response while the next pattern shifts in, and flushes the
// final response with zeros. Every unloaded response bit is folded into a
// MISR signature.
//
// Optional build macro: SCAN_RSP_STREAM_EN
//   Adds a response word stream (rsp_valid/rsp_data/rsp_ready). Unloaded bits
//   are packed LSB first; the last word of each pattern is zero padded. A
//   held, unaccepted response word stalls the chain before it is overwritten.
//
// Ports:
//   CK            in   clock, rising edge
//   RN            in   asynchronous active-low reset
//   start         in   begin a session (ignored while busy)
//   num_patterns  in   pattern count, sampled on the accepted start
//   pat_valid     in   stimulus word available
//   pat_data      in   stimulus word, bit 0 shifted first
//   pat_ready     out  stimulus word consumed this cycle
//   test_se       out  scan enable to the chain
//   test_si       out  serial data into the first scan cell
//   test_so       in   serial data from the last scan cell
//   scan_ce       out  chain clock enable
//   busy          out  session in progress
//   done          out  one-cycle pulse at session end
//   signature     out  MISR value, stable while not busy
//   rsp_valid     out  (SCAN_RSP_STREAM_EN) response word available
//   rsp_data      out  (SCAN_RSP_STREAM_EN) response word
//   rsp_ready     in   (SCAN_RSP_STREAM_EN) response word accepted
// ---------------------------------------------------------------------------
module scan_pattern_driver
    import scan_drv_pkg::*;
#(
    parameter int CHAIN_LEN = 1426,
    parameter int CNT_W     = 11,
    parameter int WORD_W    = 8,
    parameter int MISR_W    = 16
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              start,
    input  logic [15:0]       num_patterns,
    input  logic              pat_valid,
    input  logic [WORD_W-1:0] pat_data,
    output logic              pat_ready,
    output logic              test_se,
    output logic              test_si,
    input  logic              test_so,
    output logic              scan_ce,
    output logic              busy,
    output logic              done,
    output logic [MISR_W-1:0] signature
`ifdef SCAN_RSP_STREAM_EN
    ,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_data,
    input  logic              rsp_ready
`endif
);

    localparam int WB_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]  LAST_WB  = WB_W'(WORD_W - 1);

    scan_state_t state, state_d;

    logic [WORD_W-1:0] word_q;
    logic [WB_W-1:0]   wbit_q;
    logic              word_full_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [15:0]       pat_cnt_q;
    logic [15:0]       num_q;
    logic              si_q;
    logic              empty_run_q;

    logic              collect;
    logic              rsp_ok;
    logic              advance;
    logic              load;
    logic              last_bit;
    logic              cur_bit;
    logic [WB_W-1:0]   cur_idx;
    logic              misr_seed;
    logic              misr_en;

    // A chain advance carries a response bit everywhere except while the
    // first pattern shifts in, because the chain then holds no capture yet.
    assign collect  = ((state == SHIFT) && (pat_cnt_q != 16'd0)) || (state == FLUSH);
    assign last_bit = (bit_cnt_q == LAST_BIT);
    assign cur_idx  = word_full_q ? wbit_q : '0;
    assign cur_bit  = word_full_q ? word_q[wbit_q] : pat_data[0];
    assign misr_en  = advance && collect;

    // Next state and outputs. A word arriving while the register is empty is
    // shifted immediately (its bit 0 goes out in the loading cycle); with no
    // word available the chain simply holds and test_si keeps its last value.
    always_comb begin
        state_d   = state;
        test_se   = 1'b0;
        test_si   = si_q;
        scan_ce   = 1'b0;
        pat_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;
        misr_seed = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    misr_seed = 1'b1;
                    state_d   = (num_patterns == 16'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                test_se = 1'b1;
                if (rsp_ok) begin
                    if (word_full_q) begin
                        advance = 1'b1;
                    end else if (pat_valid) begin
                        advance   = 1'b1;
                        load      = 1'b1;
                        pat_ready = 1'b1;
                    end
                end
                if (advance) begin
                    scan_ce = 1'b1;
                    test_si = cur_bit;
                    if (last_bit) begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                busy    = 1'b1;
                scan_ce = 1'b1;
                state_d = ((pat_cnt_q + 16'd1) == num_q) ? FLUSH : SHIFT;
            end
            FLUSH: begin
                busy    = 1'b1;
                test_se = 1'b1;
                test_si = 1'b0;
                if (rsp_ok) begin
                    advance = 1'b1;
                    scan_ce = 1'b1;
                    if (last_bit) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // An empty session still shows one busy cycle before done.
                if (empty_run_q) begin
                    busy = 1'b1;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Serialiser, chain bit counter and pattern counter. The word register is
    // marked empty after its top bit or after the chain's last bit, so any
    // unused upper bits of a pattern's final word are dropped.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            word_q      <= '0;
            wbit_q      <= '0;
            word_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            pat_cnt_q   <= '0;
            num_q       <= '0;
            si_q        <= 1'b0;
            empty_run_q <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                num_q       <= num_patterns;
                pat_cnt_q   <= '0;
                bit_cnt_q   <= '0;
                word_full_q <= 1'b0;
                empty_run_q <= (num_patterns == 16'd0);
            end
            if (state == DONE) begin
                empty_run_q <= 1'b0;
            end
            if (advance) begin
                si_q      <= test_si;
                bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
            end
            if ((state == SHIFT) && advance) begin
                if (load) begin
                    word_q <= pat_data;
                end
                word_full_q <= !((cur_idx == LAST_WB) || last_bit);
                wbit_q      <= cur_idx + 1'b1;
            end
            if (state == CAPTURE) begin
                pat_cnt_q <= pat_cnt_q + 16'd1;
            end
        end
    end

`ifdef SCAN_RSP_STREAM_EN
    logic [WORD_W-1:0] rsp_q;
    logic [WB_W-1:0]   rbit_q;
    logic              rsp_valid_q;

    // A held word that is not being taken this cycle would be overwritten by
    // the next collected bit, so the chain waits instead.
    assign rsp_ok    = !(collect && rsp_valid_q && !rsp_ready);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_q;

    // Response packer: bit 0 of a new word clears the register, which leaves
    // the high bits of a short final word at zero.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            rsp_q       <= '0;
            rbit_q      <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            if (misr_en) begin
                if (rbit_q == '0) begin
                    rsp_q <= {{(WORD_W-1){1'b0}}, test_so};
                end else begin
                    rsp_q[rbit_q] <= test_so;
                end
                if ((rbit_q == LAST_WB) || last_bit) begin
                    rsp_valid_q <= 1'b1;
                    rbit_q      <= '0;
                end else begin
                    rbit_q <= rbit_q + 1'b1;
                end
            end
        end
    end
`else
    assign rsp_ok = 1'b1;
`endif

    scan_misr #(
        .MISR_W (MISR_W)
    ) u_misr (
        .CK   (CK),
        .RN   (RN),
        .seed (misr_seed),
        .en   (misr_en),
        .din  (test_so),
        .sig  (signature)
    );

endmodule

// File: tb/tb_scan_pattern_driver.sv
// ---------------------------------------------------------------------------
// tb_scan_pattern_driver
//
// Drives the scan pattern driver with an 8-cell chain and 4-bit words. A
// behavioural chain model shifts test_si toward test_so and, on capture,
// stores the complement of its contents. Expected chain events are queued
// when a session is issued; a monitor pops one entry per chain-clock or done
// cycle and compares.
// ---------------------------------------------------------------------------
module tb_scan_pattern_driver;

    localparam int CL = 8;
    localparam int WW = 4;

    logic          CK = 1'b0;
    logic          RN = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   num_patterns = '0;
    logic          pat_valid = 1'b0;
    logic [WW-1:0] pat_data = '0;
    logic          pat_ready;
    logic          test_se;
    logic          test_si;
    logic          test_so;
    logic          scan_ce;
    logic          busy;
    logic          done;
    logic [15:0]   signature;
`ifdef SCAN_RSP_STREAM_EN
    logic          rsp_valid;
    logic [WW-1:0] rsp_data;
    logic          rsp_ready = 1'b1;
`endif

    typedef struct {
        logic        is_done;
        logic        se;
        logic        si;
        logic        si_chk;
        logic        sig_chk;
        logic [15:0] sig;
        int          cyc;
        int          busyc;
        int          idlec;
    } ev_t;

    ev_t           sb_q[$];
    logic [WW-1:0] feed_w[$];
    int            feed_a[$];
    logic [7:0]    pat_tab[3];
    logic [CL-1:0] chain = '0;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   busy_cnt = 0;
    int   idle_cnt = 0;
    int   ev_cnt = 0;
    logic hs = 1'b0;

    scan_pattern_driver #(
        .CHAIN_LEN (CL),
        .CNT_W     (3),
        .WORD_W    (WW),
        .MISR_W    (16)
    ) dut (
        .CK           (CK),
        .RN           (RN),
        .start        (start),
        .num_patterns (num_patterns),
        .pat_valid    (pat_valid),
        .pat_data     (pat_data),
        .pat_ready    (pat_ready),
        .test_se      (test_se),
        .test_si      (test_si),
        .test_so      (test_so),
        .scan_ce      (scan_ce),
        .busy         (busy),
        .done         (done),
        .signature    (signature)
`ifdef SCAN_RSP_STREAM_EN
        ,
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_ready    (rsp_ready)
`endif
    );

    always #5 CK = ~CK;

    always @(posedge CK) cyc <= cyc + 1;

    // Chain model: first cell takes test_si, last cell drives test_so; a
    // capture loads the complement of what was shifted in.
    always @(posedge CK) begin
        if (scan_ce) begin
            if (test_se) begin
                chain <= {chain[CL-2:0], test_si};
            end else begin
                chain <= ~chain;
            end
        end
    end
    assign test_so = chain[CL-1];

    function automatic logic [15:0] ref_step(input logic [15:0] s, input logic b);
        logic [15:0] n;
        n = {s[14:0], 1'b0};
        if (s[15]) n = n ^ 16'h1021;
        n[0] = n[0] ^ b;
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " test_se"}, test_se, 0);
        checkOutput({tag, " test_si"}, test_si, 0);
        checkOutput({tag, " scan_ce"}, scan_ce, 0);
        checkOutput({tag, " pat_ready"}, pat_ready, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " signature"}, signature, 32'hFFFF);
    endtask

    // Queue the expected chain activity for pat_tab[0..npat-1] and start the
    // session. Word 1 of pattern 0 is withheld until cycle stall_at.
    task automatic applyStimulus(input int npat, input int stall_at,
                                 input int exp_cyc, input int exp_busy, input int exp_idle);
        ev_t         e;
        logic [15:0] s;
        logic [7:0]  p;
        sb_q.delete();
        feed_w.delete();
        feed_a.delete();
        s = 16'hFFFF;
        e = '{default: 0};
        for (int k = 0; k < npat; k++) begin
            p = pat_tab[k];
            feed_w.push_back(p[3:0]);
            feed_a.push_back(0);
            feed_w.push_back(p[7:4]);
            feed_a.push_back((k == 0) ? stall_at : 0);
            for (int b = 0; b < 8; b++) begin
                e = '{default: 0};
                e.se = 1'b1; e.si = p[b]; e.si_chk = 1'b1;
                sb_q.push_back(e);
            end
            e = '{default: 0};
            e.se = 1'b0; e.sig_chk = 1'b1; e.sig = s;
            sb_q.push_back(e);
            for (int b = 0; b < 8; b++) s = ref_step(s, ~p[b]);
        end
        if (npat > 0) begin
            for (int b = 0; b < 8; b++) begin
                e = '{default: 0};
                e.se = 1'b1; e.si = 1'b0; e.si_chk = 1'b1;
                sb_q.push_back(e);
            end
        end
        e = '{default: 0};
        e.is_done = 1'b1; e.sig = s; e.cyc = exp_cyc; e.busyc = exp_busy; e.idlec = exp_idle;
        sb_q.push_back(e);
        @(posedge CK); #1;
        num_patterns = 16'(npat);
        start = 1'b1;
        start_cyc = cyc;
        busy_cnt = 0;
        idle_cnt = 0;
        ev_cnt = 0;
        @(posedge CK); #1;
        start = 1'b0;
    endtask

    task automatic waitSession(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(posedge CK);
            if (sb_q.size() == 0) break;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout: %0d events pending, expected 0", tag, sb_q.size());
            sb_q.delete();
        end
        #1;
    endtask

    // Stimulus word feeder: retire the word taken at the last edge, then
    // present the next one once its availability cycle is reached.
    initial begin
        forever begin
            @(posedge CK); #1;
            if (hs && feed_w.size() > 0) begin
                void'(feed_w.pop_front());
                void'(feed_a.pop_front());
            end
            if (feed_w.size() > 0 && (cyc - start_cyc) >= feed_a[0]) begin
                pat_valid = 1'b1;
                pat_data  = feed_w[0];
            end else begin
                pat_valid = 1'b0;
            end
        end
    end

    // Monitor: one queue entry per chain-clock cycle or done pulse.
    initial begin
        ev_t e;
        forever begin
            @(negedge CK);
            hs = pat_valid && pat_ready;
            if (RN) begin
                if (busy) begin
                    busy_cnt++;
                    if (!scan_ce) idle_cnt++;
                end
                if (scan_ce || done) begin
                    ev_cnt++;
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected event: scan_ce=%0b done=%0b, expected none", scan_ce, done);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.is_done) begin
                            checkOutput("done pulse", done, 1);
                            checkOutput("busy at done", busy, 0);
                            checkOutput("scan_ce at done", scan_ce, 0);
                            checkOutput("done cycle", cyc - start_cyc, e.cyc);
                            checkOutput("busy cycles", busy_cnt, e.busyc);
                            checkOutput("stall cycles", idle_cnt, e.idlec);
                            checkOutput("final signature", signature, e.sig);
                        end else begin
                            checkOutput($sformatf("ev%0d test_se", ev_cnt), test_se, e.se);
                            checkOutput($sformatf("ev%0d early done", ev_cnt), done, 0);
                            if (e.si_chk) checkOutput($sformatf("ev%0d test_si", ev_cnt), test_si, e.si);
                            if (e.sig_chk) checkOutput($sformatf("ev%0d capture signature", ev_cnt), signature, e.sig);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1 RN = 1'b0;
        #2 checkResetOutputs("reset");
        @(negedge CK);
        RN = 1'b1;

        $display("[TB] shift order");
        pat_tab[0] = 8'h5A;
        applyStimulus(1, 0, 18, 17, 0);
        waitSession("shift order");

        $display("[TB] stall before second word");
        pat_tab[0] = 8'h5A;
        applyStimulus(1, 8, 21, 20, 3);
        waitSession("stall");

        $display("[TB] misr with three patterns, extra start ignored");
        pat_tab[0] = 8'hC3;
        pat_tab[1] = 8'h0F;
        pat_tab[2] = 8'h96;
        applyStimulus(3, 0, 36, 35, 0);
        repeat (10) @(posedge CK);
        #1 num_patterns = 16'd5;
        start = 1'b1;
        @(posedge CK); #1;
        start = 1'b0;
        waitSession("misr");

        $display("[TB] zero patterns");
        applyStimulus(0, 0, 2, 1, 1);
        waitSession("zero patterns");

        $display("[TB] reset during second pattern");
        pat_tab[0] = 8'h5A;
        pat_tab[1] = 8'hE1;
        applyStimulus(2, 0, 27, 26, 0);
        for (int i = 0; i < 100; i++) begin
            if (ev_cnt >= 12) break;
            @(posedge CK); #1;
        end
        if (ev_cnt < 12) begin
            checks++;
            failures++;
            $display("[TB] FAIL reset wait timeout: %0d events, expected 12", ev_cnt);
        end
        #2 RN = 1'b0;
        #1 checkResetOutputs("async abort");
        sb_q.delete();
        feed_w.delete();
        feed_a.delete();
        pat_valid = 1'b0;
        @(negedge CK);
        RN = 1'b1;

        $display("[TB] full session after abort");
        pat_tab[0] = 8'h3C;
        pat_tab[1] = 8'h81;
        applyStimulus(2, 0, 27, 26, 0);
        waitSession("after abort");

        repeat (3) @(posedge CK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_pattern_driver.md
Name: scan_pattern_driver

Overview:
- Tester-side master for a scan chain built from scan flops (D/SI/SE/Q).
- Serialises stimulus words onto the chain input, drives `test_se`, and issues one capture cycle per pattern.
- Unloads each pattern's response from the chain output while the next pattern shifts in, and folds every response bit into a MISR signature.
- Sits between the on-chip pattern buffer and the scan-inserted core; it drives the chain's SI/SE and receives the chain's last Q.

Parameters:
- CHAIN_LEN, 1426, number of scan cells in the chain.
- CNT_W, 11, shift counter width; must satisfy 2**CNT_W >= CHAIN_LEN.
- WORD_W, 8, stimulus/response word width.
- MISR_W, 16, signature width; the polynomial is fixed for 16.

Ports:
- CK  in  1  clock, rising edge.
- RN  in  1  asynchronous active-low reset.
- start  in  1  pulse that begins a test session.
- num_patterns  in  16  pattern count, sampled on the accepted start.
- pat_valid  in  1  stimulus word available.
- pat_data  in  WORD_W  stimulus word; LSB is shifted first.
- pat_ready  out  1  stimulus word consumed this cycle.
- test_se  out  1  scan enable to the chain.
- test_si  out  1  serial data to the first scan cell.
- test_so  in  1  serial data from the last scan cell.
- scan_ce  out  1  chain clock enable; the chain advances only when this is 1.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse at session end.
- signature  out  MISR_W  MISR value; stable while not busy.

Behaviour:
- Reset values (RN low, asynchronous):
  - test_se=0, test_si=0, scan_ce=0, pat_ready=0, busy=0, done=0.
  - signature=16'hFFFF, FSM=IDLE, all counters 0.
- FSM states: IDLE, SHIFT, CAPTURE, FLUSH, DONE.
- IDLE:
  - start=1 latches num_patterns and seeds the MISR to 16'hFFFF.
  - Next state is SHIFT, or DONE if num_patterns==0.
  - busy=1 from the cycle after start.
  - start while busy is ignored.
- SHIFT:
  - test_se=1.
  - An advance happens in a cycle when the current word register holds unconsumed bits, or when a word is being loaded this cycle.
  - In an advance cycle: scan_ce=1, test_si = current bit, bit index increments.
  - pat_ready=1 in a cycle where the word register is empty/consumed, a word is needed, and pat_valid=1. That word loads and its bit 0 is shifted in the same cycle (zero-bubble).
  - If a word is needed and pat_valid=0: scan_ce=0, test_si holds its last value, nothing advances (stall).
  - After CHAIN_LEN advances, go to CAPTURE. If CHAIN_LEN%WORD_W != 0, the unused upper bits of the last word are discarded.
- CAPTURE:
  - Exactly one cycle: test_se=0, scan_ce=1, pattern counter increments.
  - Next state is SHIFT if patterns remain, else FLUSH.
- FLUSH:
  - test_se=1, test_si=0, scan_ce=1 every cycle, no stalls, for CHAIN_LEN cycles; then DONE.
- DONE:
  - done=1 and busy=0 for one cycle, then IDLE.
- MISR:
  - Updated on every advance cycle of SHIFT and FLUSH, except during the first pattern's SHIFT, which carries no valid response.
  - Update rule: sig_next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0) ^ {15'b0, test_so}.
  - test_so is sampled in the same cycle as the advance.
  - Not updated in CAPTURE or during stalls.
- Timing:
  - The bit counter counts 0..CHAIN_LEN-1 with a terminal-count compare; there is no wrap beyond CHAIN_LEN-1.
  - The pattern counter is 16 bits; num_patterns=16'hFFFF runs 65535 patterns.
  - Session latency with no stalls: 1 + num_patterns*(CHAIN_LEN+1) + CHAIN_LEN cycles from start to done.
- Reset asserted mid-session aborts immediately; all outputs return to their reset values and the partial signature is lost.

Optional Feature:
- Macro SCAN_RSP_STREAM_EN.
- When defined:
  - Adds ports rsp_valid (out, 1), rsp_data (out, WORD_W) and rsp_ready (in, 1).
  - Unloaded bits are packed LSB-first into words; rsp_valid is asserted with each full word.
  - The final word of each pattern is zero-padded in its high bits.
  - While rsp_valid=1 and rsp_ready=0, and the next bit would overwrite the word, SHIFT and FLUSH stall (scan_ce=0).
  - rsp_valid resets to 0; rsp_data resets to 0.
  - The MISR still runs.
- When undefined: no response ports and no backpressure; the signature is the only observation.

Decomposition:
- Package scan_drv_pkg holds:
  - FSM state enum.
  - MISR_POLY = 16'h1021.
  - MISR_SEED = 16'hFFFF.
- One sub-module, scan_misr: signature register with seed, enable and serial input.
- Serialiser, response packer and FSM stay in the top module.

Test Plan:
- Shift order: CHAIN_LEN=8, WORD_W=4, num_patterns=1, words 4'hA then 4'h5 with no stall. Required:
  - test_si sequence 0,1,0,1,1,0,1,0 over 8 advance cycles.
  - One CAPTURE cycle with test_se=0.
  - 8 FLUSH cycles, then done at cycle 18 after start.
- Stall: same configuration as the shift-order case, pat_valid low for 3 cycles before the second word. Required:
  - scan_ce=0 for exactly those 3 cycles.
  - Bit sequence unchanged; done delayed by 3 cycles.
- MISR check: chain model that returns test_so = the captured complement of the loaded bits. Required:
  - Signature equals the reference model computed with poly 16'h1021 and seed 16'hFFFF.
  - First-pattern SHIFT leaves the signature at 16'hFFFF.
- Zero patterns: num_patterns=0. Required:
  - busy=1 for one cycle, then done pulses with no scan_ce.
  - signature=16'hFFFF.
- Reset mid-SHIFT: RN pulsed low at bit 3 of pattern 2. Required:
  - All outputs return to reset values asynchronously.
  - A new start runs a full correct session.
- (SCAN_RSP_STREAM_EN) CHAIN_LEN=6, WORD_W=4, rsp_ready held low on the first word. Required:
  - Shifting stalls at bit 4.
  - Second word is zero-padded: bits [3:2]=0.
